// File: rtl/apb_arb_master_pkg.sv
// rtl/apb_arb_master_pkg.sv - shared types and constants for the APB arbitrating master
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_ctrl_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

  typedef struct packed {
    logic slverr;
    logic timeout;
  } apb_rsp_status_t;

endpackage

// File: rtl/apb_arb_master_if.sv
// rtl/apb_arb_master_if.sv - requester and APB bus signal bundle for apb_arb_master
interface apb_arb_master_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_slverr;
  logic                      rsp_timeout;
  logic                      psel;
  logic                      penable;
  logic                      pwrite;
  logic [ADDR_W-1:0]         paddr;
  logic [DATA_W-1:0]         pwdata;
  logic [DATA_W-1:0]         prdata;
  logic                      pready;
  logic                      pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_arb_master_arbiter.sv
// rtl/apb_arb_master_arbiter.sv - round-robin arbiter owning the last-grant pointer
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      grant_idx_o
);
  logic [IW-1:0] last_q;
  logic          found;
  int            cand;

  // Search upward from the requester after the last winner, wrapping around
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_q) + k) % NUM_REQ;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = en_i;
        grant_idx_o   = IW'(cand);
      end
    end
  end

  // Pointer moves only when a grant is actually issued; reset makes requester 0 first
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= IW'(NUM_REQ - 1);
    end else if (|grant_o) begin
      last_q <= grant_idx_o;
    end
  end
endmodule

// File: rtl/apb_arb_master.sv
// rtl/apb_arb_master.sv - round-robin APB master with wait-state timeout
module apb_arb_master
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             reset,
  apb_arb_master_if.master bus
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_SETUP  = ST_SETUP;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;

  logic [1:0]         state_q, state_d;
  logic               write_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [IW-1:0]      idx_q;
  logic [CW-1:0]      cnt_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rdata_q;
  apb_rsp_status_t    status_q;

  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_en;
  logic               granted;
  logic               in_access;
  logic               timeout_hit;
  logic               finish;

  assign grant_en    = (state_q == S_IDLE) && !reset;
  assign granted     = |grant;
  assign in_access   = (state_q == S_ACCESS);
  assign timeout_hit = in_access && !bus.pready && (cnt_q == CW'(TIMEOUT - 1));
  assign finish      = in_access && (bus.pready || timeout_hit);

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req_i       (bus.req_valid),
    .en_i        (grant_en),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  // Transfer sequencing: one request at a time through SETUP and ACCESS
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (granted) state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: if (finish) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Latch the winner's payload; it stays on the bus until the next grant
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
    end else if (granted) begin
      write_q <= bus.req_write[grant_idx];
      addr_q  <= bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
      wdata_q <= bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
      idx_q   <= grant_idx;
    end
  end

  // Count ACCESS cycles spent waiting on pready, restarting for each transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state_q == S_SETUP) begin
      cnt_q <= '0;
    end else if (in_access && !bus.pready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // One-cycle response to the issuing requester; an abort reports error with zero data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid_q <= '0;
      rdata_q     <= '0;
      status_q    <= '0;
    end else begin
      rsp_valid_q      <= finish ? (NUM_REQ'(1) << idx_q) : '0;
      rdata_q          <= (finish && bus.pready && !write_q) ? bus.prdata : '0;
      status_q.slverr  <= finish && (bus.pready ? bus.pslverr : 1'b1);
      status_q.timeout <= finish && !bus.pready;
    end
  end

  assign bus.req_ready   = grant;
  assign bus.psel        = (state_q != S_IDLE);
  assign bus.penable     = in_access;
  assign bus.pwrite      = write_q;
  assign bus.paddr       = addr_q;
  assign bus.pwdata      = wdata_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.rsp_slverr  = status_q.slverr;
  assign bus.rsp_timeout = status_q.timeout;
endmodule

// File: tb/tb_apb_arb_master.sv
// tb/tb_apb_arb_master.sv - scoreboard bench for apb_arb_master
module tb_apb_arb_master;
  localparam int NR = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  apb_arb_master_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

  apb_arb_master #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            w;
    logic          err;
  } plan_t;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          slverr;
    logic          tmo;
    int            at;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_q[$];

  bit            pend[NR];
  logic          p_write[NR];
  logic [AW-1:0] p_addr[NR];
  logic [DW-1:0] p_wdata[NR];
  int            last_grant = NR - 1;
  int            busy_until = 0;

  int            dir_w[$];
  bit            dir_e[$];
  logic [DW-1:0] dir_rd[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]              = pend[i];
      bus.req_write[i]              = p_write[i];
      bus.req_addr[i*AW +: AW]      = p_addr[i];
      bus.req_wdata[i*DW +: DW]     = p_wdata[i];
    end
  endtask

  // Model of an accepted transfer: slave behaviour is planned, response predicted
  task automatic grant(input int win);
    plan_t         p;
    exp_t          e;
    int            w;
    int            r;
    bit            er;
    logic [DW-1:0] rd;
    if (dir_w.size() > 0) begin
      w  = dir_w.pop_front();
      er = dir_e.pop_front();
      rd = dir_rd.pop_front();
    end else begin
      r  = $urandom_range(0, 99);
      w  = (r < 60) ? $urandom_range(0, 3) : (r < 85) ? $urandom_range(4, 13) : $urandom_range(14, 20);
      er = ($urandom_range(0, 9) == 0);
      rd = $urandom;
    end
    p.write = p_write[win];
    p.addr  = p_addr[win];
    p.wdata = p_wdata[win];
    p.rdata = rd;
    p.w     = w;
    p.err   = er;
    plan_q.push_back(p);
    e.id     = win;
    e.tmo    = (w >= TO);
    e.slverr = e.tmo ? 1'b1 : er;
    e.rdata  = (e.tmo || p_write[win]) ? '0 : rd;
    e.at     = cyc + 3 + ((w < TO) ? w : TO - 1);
    exp_q.push_back(e);
    busy_until = e.at;
    last_grant = win;
    pend[win]  = 1'b0;
  endtask

  // One cycle of requester activity plus the predicted accept strobe
  task automatic step(input int prob_new);
    logic [NR-1:0] exp_ready;
    int            win;
    @(negedge clk);
    for (int i = 0; i < NR; i++) begin
      if (!pend[i] && ($urandom_range(0, 99) < prob_new)) begin
        pend[i]    = 1'b1;
        p_write[i] = $urandom_range(0, 1);
        p_addr[i]  = $urandom;
        p_wdata[i] = $urandom;
      end
    end
    drive();
    win = -1;
    if (cyc >= busy_until) begin
      for (int k = 1; k <= NR; k++) begin
        int c = (last_grant + k) % NR;
        if (win < 0 && pend[c]) win = c;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    #1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    if (win >= 0) grant(win);
  endtask

  task automatic enqueue(input int id, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input int w, input bit er,
                         input logic [DW-1:0] rd);
    pend[id]    = 1'b1;
    p_write[id] = wr;
    p_addr[id]  = a;
    p_wdata[id] = wd;
    dir_w.push_back(w);
    dir_e.push_back(er);
    dir_rd.push_back(rd);
  endtask

  task automatic any_pend(output bit b);
    b = 1'b0;
    for (int i = 0; i < NR; i++) if (pend[i]) b = 1'b1;
  endtask

  task automatic drain(input string name);
    bit b;
    int n;
    n = 0;
    any_pend(b);
    while ((b || exp_q.size() > 0) && n < 300) begin
      step(0);
      any_pend(b);
      n++;
    end
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
  endtask

  // APB slave: follows the plan of each transfer and checks the bus payload
  initial begin
    plan_t cur;
    int    acc;
    bit    have;
    have = 1'b0;
    acc  = 0;
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    bus.prdata  = '0;
    forever begin
      @(negedge clk);
      bus.pready  = 1'b0;
      bus.pslverr = 1'($urandom_range(0, 1));
      bus.prdata  = $urandom;
      if (reset) begin
        have = 1'b0;
      end else if (bus.psel && !bus.penable) begin
        check("setup_has_plan", 64'(plan_q.size() > 0), 64'(1));
        if (plan_q.size() > 0) begin
          cur  = plan_q.pop_front();
          have = 1'b1;
          acc  = 0;
          check("setup_paddr", 64'(bus.paddr), 64'(cur.addr));
          check("setup_pwrite", 64'(bus.pwrite), 64'(cur.write));
        end
      end else if (bus.psel && bus.penable && have) begin
        check("access_paddr", 64'(bus.paddr), 64'(cur.addr));
        check("access_pwrite", 64'(bus.pwrite), 64'(cur.write));
        check("access_pwdata", 64'(bus.pwdata), 64'(cur.wdata));
        if (acc == cur.w) begin
          bus.pready  = 1'b1;
          bus.pslverr = cur.err;
          bus.prdata  = cur.rdata;
        end
        acc++;
      end
    end
  end

  // Response monitor: pops the scoreboard whenever any completion strobe appears
  initial begin
    exp_t          e;
    logic [NR-1:0] oh;
    forever begin
      @(negedge clk);
      if (!reset && bus.rsp_valid != '0) begin
        check("rsp_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e  = exp_q.pop_front();
          oh = '0;
          oh[e.id] = 1'b1;
          check("rsp_valid_id", 64'(bus.rsp_valid), 64'(oh));
          check("rsp_cycle", 64'(cyc), 64'(e.at));
          check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          check("rsp_slverr", 64'(bus.rsp_slverr), 64'(e.slverr));
          check("rsp_timeout", 64'(bus.rsp_timeout), 64'(e.tmo));
          check("rsp_psel_low", 64'(bus.psel), 64'(0));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      pend[i]    = 1'b1;
      p_write[i] = 1'b1;
      p_addr[i]  = $urandom;
      p_wdata[i] = $urandom;
    end
    drive();
    repeat (3) @(negedge clk);
    #1;
    check("reset_psel", 64'(bus.psel), 64'(0));
    check("reset_penable", 64'(bus.penable), 64'(0));
    check("reset_pwrite", 64'(bus.pwrite), 64'(0));
    check("reset_paddr", 64'(bus.paddr), 64'(0));
    check("reset_pwdata", 64'(bus.pwdata), 64'(0));
    check("reset_req_ready", 64'(bus.req_ready), 64'(0));
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'(0));
    check("reset_rsp_slverr", 64'(bus.rsp_slverr), 64'(0));
    check("reset_rsp_timeout", 64'(bus.rsp_timeout), 64'(0));
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    drive();
    @(negedge clk);
    reset = 1'b0;

    enqueue(2, 1'b1, 32'h100, 32'hDEAD_BEEF, 0, 1'b0, 32'h0);
    drain("zero_wait_write");
    enqueue(0, 1'b0, 32'h20, 32'h0, 3, 1'b0, 32'h1234_5678);
    drain("read_3_waits");
    enqueue(3, 1'b0, 32'h44, 32'h0, 1, 1'b1, 32'hCAFE_F00D);
    drain("pslverr");
    enqueue(1, 1'b0, 32'h80, 32'h0, 40, 1'b0, 32'h5555_AAAA);
    drain("timeout_stuck");
    enqueue(1, 1'b0, 32'h84, 32'h0, TO - 1, 1'b0, 32'h0BAD_CAFE);
    drain("pready_at_limit");
    enqueue(2, 1'b1, 32'h88, 32'h1111_2222, TO, 1'b0, 32'h0);
    drain("timeout_at_limit");

    repeat (40) step(100);
    drain("all_valid");

    enqueue(1, 1'b0, 32'h300, 32'h0, 10, 1'b0, 32'h7777_8888);
    for (int n = 0; n < 50 && pend[1]; n++) step(0);
    repeat (3) step(0);
    #1 reset = 1'b1;
    #1;
    check("midreset_psel", 64'(bus.psel), 64'(0));
    check("midreset_penable", 64'(bus.penable), 64'(0));
    check("midreset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    plan_q.delete();
    exp_q.delete();
    for (int i = 0; i < NR; i++) pend[i] = 1'b0;
    last_grant = NR - 1;
    busy_until = 0;
    drive();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    enqueue(2, 1'b1, 32'h400, 32'h9, 0, 1'b0, 32'h0);
    enqueue(0, 1'b0, 32'h404, 32'h0, 0, 1'b0, 32'hABCD_0123);
    drain("after_reset");

    repeat (1500) step(30);
    drain("random");
    check("plan_empty", 64'(plan_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
